// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared receiver state, prefix codes and key event type for the PS/2 keyboard receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - show-ahead key event FIFO with registered head and overflow pulse
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 2
) (
    input  logic     clk_sys,
    input  logic     reset,
    input  logic     wr_en,
    input  key_evt_t wr_data,
    input  logic     rd_ready,
    output logic     rd_valid,
    output key_evt_t rd_data,
    output logic     overflow
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] FULL_CNT = {1'b1, {FIFO_BITS{1'b0}}};
    localparam logic [FIFO_BITS:0] ONE_CNT  = (FIFO_BITS + 1)'(1);

    key_evt_t               mem [DEPTH];
    logic [FIFO_BITS-1:0]   wr_ptr;
    logic [FIFO_BITS-1:0]   rd_ptr;
    logic [FIFO_BITS-1:0]   rd_ptr_nxt;
    logic [FIFO_BITS:0]     count;
    logic [FIFO_BITS:0]     count_nxt;
    logic                   full;
    logic                   do_pop;
    logic                   do_wr;
    key_evt_t               head_nxt;

    assign full       = (count == FULL_CNT);
    assign do_pop     = rd_valid & rd_ready;
    assign do_wr      = wr_en & (~full | do_pop);
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    // Head is registered, so the next head is chosen one cycle ahead:
    // a write into an empty (or emptying) FIFO bypasses the memory.
    always_comb begin
        count_nxt = count;
        if (do_wr && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_wr)
            count_nxt = count - 1'b1;

        head_nxt = rd_data;
        if (do_wr && (count == '0 || (do_pop && count == ONE_CNT)))
            head_nxt = wr_data;
        else if (do_pop)
            head_nxt = mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk_sys) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr_nxt;
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            rd_data  <= head_nxt;
            overflow <= wr_en & full & ~do_pop;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver, E0/F0 prefix decoder and event queue
// Parity checking is enabled by defining PS2_KBD_RX_PARITY_CHK_EN.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16384,
    parameter int FIFO_BITS   = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_prev;
    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            ext_flag;
    logic            rel_flag;
    logic [TO_W-1:0] to_cnt;
    key_evt_t        evt;
    logic            evt_wr;
    key_evt_t        head;
    logic            fall;
    logic            bit_in;
    logic            timeout;
    logic            stop_bad;

    assign fall    = clk_prev & ~clk_sync[1];
    assign bit_in  = data_sync[1];
    assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

`ifdef PS2_KBD_RX_PARITY_CHK_EN
    logic par_acc;
    logic par_err;
    assign stop_bad = ~bit_in | par_err;
`else
    assign stop_bad = ~bit_in;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ext_flag  <= 1'b0;
            rel_flag  <= 1'b0;
            to_cnt    <= '0;
            evt       <= '0;
            evt_wr    <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_KBD_RX_PARITY_CHK_EN
            par_acc   <= 1'b1;
            par_err   <= 1'b0;
`endif
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            evt_wr    <= 1'b0;
            frame_err <= 1'b0;
            to_cnt    <= (state == ST_IDLE || fall) ? '0 : to_cnt + 1'b1;

            if (timeout) begin
                state    <= ST_IDLE;
                frame_err <= 1'b1;
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!bit_in) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
`ifdef PS2_KBD_RX_PARITY_CHK_EN
                            par_acc <= 1'b1;
`endif
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef PS2_KBD_RX_PARITY_CHK_EN
                        par_acc <= par_acc ^ bit_in;
`endif
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_KBD_RX_PARITY_CHK_EN
                        // accumulator seeded with 1, so odd parity leaves it equal to the parity bit
                        par_err <= par_acc ^ bit_in;
`endif
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (stop_bad) begin
                            frame_err <= 1'b1;
                            ext_flag  <= 1'b0;
                            rel_flag  <= 1'b0;
                        end else if (shreg == PS2_EXT) begin
                            ext_flag <= 1'b1;
                        end else if (shreg == PS2_REL) begin
                            rel_flag <= 1'b1;
                        end else begin
                            evt_wr   <= 1'b1;
                            evt      <= '{code: shreg, ext: ext_flag, rel: rel_flag};
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    ps2_evt_fifo #(
        .FIFO_BITS (FIFO_BITS)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .wr_en    (evt_wr),
        .wr_data  (evt),
        .rd_ready (key_ready),
        .rd_valid (key_valid),
        .rd_data  (head),
        .overflow (overflow)
    );

    assign key_code    = head.code;
    assign key_ext     = head.ext;
    assign key_release = head.rel;

endmodule
